// File: rtl/dot_accum_pkg.sv
// Shared types and the saturating output formatter for dot_accum.
package dot_accum_pkg;

    localparam int PROD_W    = 64;
    localparam int SAT_MAX_W = 128;

    typedef logic signed [PROD_W-1:0] prod_t;

    typedef struct packed {
        logic                        sat;
        logic signed [SAT_MAX_W-1:0] value;
    } sat_res_t;

    // sum holds an acc_w-bit signed value; result is clamped to the out_w-bit signed range.
    function automatic sat_res_t sat_trunc(input logic signed [SAT_MAX_W-1:0] sum,
                                           input int acc_w,
                                           input int out_w);
        logic signed [SAT_MAX_W-1:0] ext;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_res_t                    res;
        ext = (sum <<< (SAT_MAX_W - acc_w)) >>> (SAT_MAX_W - acc_w);
        hi  = $signed((128'd1 << (out_w - 1)) - 128'd1);
        lo  = -hi - 128'sd1;
        res.sat = 1'b0;
        res.value = ext;
        if (ext > hi) begin
            res.sat   = 1'b1;
            res.value = hi;
        end else if (ext < lo) begin
            res.sat   = 1'b1;
            res.value = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/dot_accum_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module dot_accum_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_eff, pop_eff;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    // Empty FIFO presents zero rather than stale contents.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        mem_d    = mem_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        pop_eff  = pop_i && !empty_o;
        push_eff = push_i && (!full_o || pop_eff);
        if (push_eff) begin
            mem_d[wr_q] = data_i;
            wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
        end
        if (pop_eff) begin
            rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        end
        if (push_eff && !pop_eff) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_eff && !push_eff) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dot_accum.sv
// Accumulates VEC_LEN valid products into dot-product sums queued in an output FIFO.
// Optional saturation of the output sum is enabled by defining DOT_ACCUM_SAT_EN.
module dot_accum
    import dot_accum_pkg::*;
#(
    parameter int VEC_LEN   = 8,
    parameter int ACC_W     = 72,
    parameter int OUT_W     = 64,
    parameter int OUT_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    input  prod_t                        in_product_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [OUT_W-1:0]             out_sum_o,
    output logic                         out_sat_o,
    output logic [$clog2(VEC_LEN):0]     elem_idx_o,
    output logic                         drop_o
);

    localparam int IDX_W = $clog2(VEC_LEN) + 1;
`ifdef DOT_ACCUM_SAT_EN
    localparam int ENT_W = OUT_W + 1;
`else
    localparam int ENT_W = OUT_W;
`endif

    if (VEC_LEN < 1 || ACC_W < PROD_W + $clog2(VEC_LEN) || OUT_W > ACC_W ||
        ACC_W > SAT_MAX_W || OUT_DEPTH < 1) begin : g_bad_cfg
        $error("dot_accum: illegal parameter combination");
    end

    logic signed [ACC_W-1:0] acc_q, acc_d, sum_next, prod_ext;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    drop_q, drop_d;
    logic                    push, pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]        push_data, head_data;
`ifdef DOT_ACCUM_SAT_EN
    sat_res_t                fmt;
`endif

    always_comb begin
        prod_ext = ACC_W'(in_product_i);
        sum_next = ((idx_q == '0) ? '0 : acc_q) + prod_ext;
        acc_d    = acc_q;
        idx_d    = idx_q;
        push     = 1'b0;
        if (in_valid_i) begin
            acc_d = sum_next;
            if (idx_q == IDX_W'(VEC_LEN - 1)) begin
                idx_d = '0;
                push  = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        pop    = !fifo_empty && out_ready_i;
        drop_d = drop_q | (push & fifo_full & ~pop);
`ifdef DOT_ACCUM_SAT_EN
        fmt       = sat_trunc(SAT_MAX_W'(sum_next), ACC_W, OUT_W);
        push_data = {fmt.sat, fmt.value[OUT_W-1:0]};
`else
        push_data = sum_next[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            idx_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            drop_q <= drop_d;
        end
    end

    dot_accum_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid_o = !fifo_empty;
    assign out_sum_o   = head_data[OUT_W-1:0];
    assign elem_idx_o  = idx_q;
    assign drop_o      = drop_q;
`ifdef DOT_ACCUM_SAT_EN
    assign out_sat_o   = head_data[OUT_W];
`else
    assign out_sat_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dot_accum.sv
// Directed and random checks of dot_accum against a queue-based reference model.
module tb_dot_accum;

    localparam int VEC_LEN   = 4;
    localparam int ACC_W     = 72;
    localparam int OUT_W     = 64;
    localparam int OUT_DEPTH = 2;
    localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] MINV = -MAXV - 128'sd1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              in_valid_i = 1'b0;
    logic [63:0]       in_product_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [OUT_W-1:0]  out_sum_o;
    logic              out_sat_o;
    logic [$clog2(VEC_LEN):0] elem_idx_o;
    logic              drop_o;

    int total = 0;
    int bad   = 0;

    logic signed [63:0] m_cur[$];
    logic [64:0]        m_q[$];
    logic               m_drop = 1'b0;

    dot_accum #(
        .VEC_LEN   (VEC_LEN),
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_product_i (in_product_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_sum_o    (out_sum_o),
        .out_sat_o    (out_sat_o),
        .elem_idx_o   (elem_idx_o),
        .drop_o       (drop_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected FIFO entry {sat, sum} for a mathematically exact dot product.
    function automatic logic [64:0] fmt(input logic signed [127:0] s);
`ifdef DOT_ACCUM_SAT_EN
        if (s > MAXV) return {1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
        if (s < MINV) return {1'b1, 64'h8000_0000_0000_0000};
`endif
        return {1'b0, s[63:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [63:0] p, input logic r, input logic rs);
        logic signed [127:0] s;
        logic [64:0]         ent;
        logic                ent_v;
        logic                pop;
        in_valid_i   = v;
        in_product_i = p;
        out_ready_i  = r;
        rst_i        = rs;
        @(posedge clk_i);
        if (rs) begin
            m_cur.delete();
            m_q.delete();
            m_drop = 1'b0;
        end else begin
            pop   = (m_q.size() > 0) && r;
            ent_v = 1'b0;
            ent   = '0;
            if (v) begin
                m_cur.push_back($signed(p));
                if (m_cur.size() == VEC_LEN) begin
                    s = '0;
                    foreach (m_cur[i]) s = s + m_cur[i];
                    ent   = fmt(s);
                    ent_v = 1'b1;
                    m_cur.delete();
                end
            end
            if (pop) void'(m_q.pop_front());
            if (ent_v) begin
                if (m_q.size() < OUT_DEPTH) m_q.push_back(ent);
                else m_drop = 1'b1;
            end
        end
        #1;
        chk("out_valid", 64'(out_valid_o), 64'(m_q.size() > 0));
        chk("out_sum", out_sum_o, (m_q.size() > 0) ? m_q[0][63:0] : 64'd0);
        chk("out_sat", 64'(out_sat_o), (m_q.size() > 0) ? 64'(m_q[0][64]) : 64'd0);
        chk("elem_idx", 64'(elem_idx_o), 64'(m_cur.size()));
        chk("drop", 64'(drop_o), 64'(m_drop));
    endtask

    task automatic vec4(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [63:0] d, input logic r);
        step(1'b1, a, r, 1'b0);
        step(1'b1, b, r, 1'b0);
        step(1'b1, c, r, 1'b0);
        step(1'b1, d, r, 1'b0);
    endtask

    initial begin
        logic [63:0] p;
        int          k;
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Basic vector, single output pulse.
        vec4(64'd1, 64'd2, 64'd3, 64'd4, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Bubbles inside a vector.
        step(1'b1, -64'sd5, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 64'd7, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, -64'sd1, 1'b1, 1'b0);
        step(1'b1, 64'd9, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);

        // Overflow past 64 bits: wraps to 0, or saturates with the macro.
        vec4(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
             64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);

        // Stalled consumer: third sum dropped.
        vec4(64'd1, 64'd2, 64'd3, 64'd4, 1'b0);
        vec4(64'd5, 64'd5, 64'd5, 64'd5, 1'b0);
        vec4(64'd6, 64'd7, 64'd8, 64'd9, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);

        // Full FIFO with simultaneous pop and push.
        step(1'b0, '0, 1'b0, 1'b1);
        vec4(64'd1, 64'd2, 64'd3, 64'd4, 1'b0);
        vec4(64'd5, 64'd5, 64'd5, 64'd5, 1'b0);
        step(1'b1, 64'd7, 1'b0, 1'b0);
        step(1'b1, 64'd7, 1'b0, 1'b0);
        step(1'b1, 64'd7, 1'b0, 1'b0);
        step(1'b1, 64'd9, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-vector discards the partial sum.
        step(1'b1, 64'd1, 1'b1, 1'b0);
        step(1'b1, 64'd2, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        vec4(64'd3, 64'd4, 64'd5, 64'd6, 1'b1);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 3);
            case (k)
                0: p = 64'(longint'($urandom_range(0, 2000)) - 64'sd1000);
                1: p = {$urandom, $urandom};
                2: p = 64'h4000_0000_0000_0000;
                default: p = 64'hC000_0000_0000_0000;
            endcase
            step($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_accum.md
Name: dot_accum

Overview:
- Downstream stage of vector_mul_simple.
- Consumes its valid-qualified stream of signed 64-bit products and accumulates every VEC_LEN consecutive valid products into one dot-product sum.
- Completed sums go into a small output FIFO with a valid/ready handshake, so the consumer can stall while the multiplier, which has no ready, keeps streaming.

Parameters:
- VEC_LEN, 8, valid products per dot product (>=1).
- ACC_W, 72, internal accumulator width; elaboration error if ACC_W < 64 + $clog2(VEC_LEN) or VEC_LEN < 1.
- OUT_W, 64, width of out_sum_o (<= ACC_W).
- OUT_DEPTH, 2, output FIFO entries (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- in_valid_i  in  1  product valid; driven from vector_mul_simple out_valid_o.
- in_product_i  in  64  signed product; driven from out_result_o.
- out_valid_o  out  1  FIFO non-empty.
- out_ready_i  in  1  consumer accepts the head entry.
- out_sum_o  out  OUT_W  signed dot-product sum at the FIFO head.
- out_sat_o  out  1  head sum was saturated (0 when the SAT macro is off).
- elem_idx_o  out  $clog2(VEC_LEN)+1  index of the next element within the current vector.
- drop_o  out  1  sticky: a completed sum was lost because the FIFO was full.

Behaviour:
- Reset (rst_i=1 at clk edge):
  - acc=0, elem_idx_o=0, FIFO emptied.
  - out_valid_o=0, out_sum_o=0, out_sat_o=0, drop_o=0.
  - Reset mid-vector discards the partial sum; the first valid product after reset is element 0.
- in_valid_i=0: no state change to acc or idx. Bubbles never break a vector.
- in_valid_i=1: input is always accepted (no input backpressure).
  - sum_next = (idx==0 ? 0 : acc) + sign-extend(in_product_i) to ACC_W.
  - acc <= sum_next.
  - If idx==VEC_LEN-1: idx <= 0 and sum_next (after output formatting) is pushed into the FIFO. Otherwise idx <= idx+1.
- Latency: a sum is visible on out_valid_o/out_sum_o in the cycle after its last element's clock edge, if the FIFO was empty.
- Output formatting: without the macro, out_sum_o = sum_next[OUT_W-1:0] (two's-complement wrap).
- FIFO:
  - Pop occurs when out_valid_o && out_ready_i.
  - Order is strictly FIFO; head data is held stable while out_valid_o=1 and out_ready_i=0.
  - Push when full with a pop in the same cycle: both happen and the count is unchanged.
  - Push when full with no pop: the new sum is discarded and drop_o <= 1 (sticky until reset). acc and idx still advance normally.
  - Pop when empty: ignored.
- VEC_LEN=1: every valid product is pushed directly.

Optional Feature:
- Macro: DOT_ACCUM_SAT_EN.
- Defined:
  - Formatting saturates sum_next to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - An out_sat flag is stored with each FIFO entry and presented as out_sat_o; it is 1 iff clamping occurred.
- Undefined:
  - Wrap truncation only.
  - out_sat_o is tied to 0 and no flag storage is generated.

Decomposition:
- Package dot_accum_pkg:
  - PROD_W=64.
  - typedef prod_t (logic signed [PROD_W-1:0]).
  - Function sat_trunc(sum, acc_w, out_w), returning value and flag.
- Sub-module dot_accum_fifo:
  - Parameterized synchronous FIFO (WIDTH, DEPTH).
  - push/pop/full/empty.
  - Same-cycle push+pop when full is allowed.

Test Plan (VEC_LEN=4, OUT_W=64, ACC_W=72 unless noted):
- Reset, then products 1,2,3,4 on consecutive cycles with out_ready_i=1 -> out_valid_o=1 for exactly one cycle, in the cycle after the 4th edge, with out_sum_o=10; elem_idx_o goes 0,1,2,3,0.
- Products -5,7 with 3 bubble cycles between, then -1,9 -> single out_sum_o=10, no extra valid pulses.
- Four products of 0x4000_0000_0000_0000 (2^62, i.e. (-2^31)*(-2^31)):
  - Macro off -> out_sum_o=0, out_sat_o=0.
  - Macro on -> out_sum_o=0x7FFF_FFFF_FFFF_FFFF, out_sat_o=1.
- out_ready_i=0; three vectors complete with sums 10, 20, 30 -> FIFO holds 10 and 20, 30 is dropped, drop_o=1. Then out_ready_i=1 -> pops 10 then 20, then out_valid_o=0.
- FIFO full (10, 20) and out_ready_i=1 in the same cycle a third vector completes with 30 -> 10 popped, 30 accepted, drop_o stays 0; subsequent pops give 20 then 30.
- rst_i asserted after products 1,2 of a vector; after reset, products 3,4,5,6 -> out_sum_o=18 (partial 1+2 discarded), FIFO empty immediately after reset.
